// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Pulse widths latch at frame boundaries with optional per-frame slew limit.
module servo_pwm_multi #(
    parameter int NUM_CH    = 4,
    parameter int PERIOD    = 2000000,
    parameter int MIN_PULSE = 100000,
    parameter int MAX_PULSE = 200000,
    parameter int POS_W     = 8,
    parameter int SLEW_W    = 20,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              pos_wr,
    input  logic [CH_W-1:0]   pos_ch,
    input  logic [POS_W-1:0]  pos_data,
    input  logic [SLEW_W-1:0] slew,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start
);

    localparam int CNT_W  = $clog2(PERIOD);
    localparam int W      = $clog2(MAX_PULSE + 1);
    localparam int SPAN   = MAX_PULSE - MIN_PULSE;
    localparam int PROD_W = POS_W + W;
    localparam int CW     = (W > SLEW_W) ? W : SLEW_W;

    localparam logic [W-1:0]     CENTRE = W'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [W-1:0]     MIN_W  = W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

    if (!(MIN_PULSE < MAX_PULSE && MAX_PULSE < PERIOD &&
          NUM_CH >= 1 && NUM_CH <= 16)) begin : g_bad_params
        $error("servo_pwm_multi: illegal parameter set");
    end

    logic [CNT_W-1:0]  counter;
    logic [W-1:0]      target   [NUM_CH];
    logic [W-1:0]      cur      [NUM_CH];
    logic [W-1:0]      next_cur [NUM_CH];
    logic [PROD_W-1:0] prod;
    logic [W-1:0]      new_width;
    logic [W-1:0]      step;
    logic              frame_end;
    logic              write_ok;

    // Position to width: full-width product, then scale down by 2^POS_W.
    always_comb begin
        prod      = PROD_W'(pos_data) * PROD_W'(SPAN);
        new_width = MIN_W + W'(prod >> POS_W);
        step      = W'(slew);
        frame_end = en && (counter == LAST);
        write_ok  = pos_wr && (32'(pos_ch) < NUM_CH);
    end

    // Slew-limited next width per channel; saturates exactly at target.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            next_cur[i] = target[i];
            if (target[i] >= cur[i]) begin
                if (slew != '0 && CW'(target[i] - cur[i]) > CW'(slew))
                    next_cur[i] = cur[i] + step;
            end else begin
                if (slew != '0 && CW'(cur[i] - target[i]) > CW'(slew))
                    next_cur[i] = cur[i] - step;
            end
        end
    end

    // Frame counter and registered pulse / frame-start outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            counter     <= '0;
            frame_start <= 1'b0;
            pwm         <= '0;
        end else begin
            frame_start <= en && (counter == '0);
            for (int i = 0; i < NUM_CH; i++)
                pwm[i] <= en && (counter < CNT_W'(cur[i]));
            if (!en || counter == LAST)
                counter <= '0;
            else
                counter <= counter + CNT_W'(1);
        end
    end

    // Targets take writes any time; active widths move only at frame end.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= CENTRE;
                cur[i]    <= CENTRE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (frame_end)
                    cur[i] <= next_cur[i];
                if (write_ok && pos_ch == CH_W'(i))
                    target[i] <= new_width;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: per-frame pulse widths, slew,
// boundary writes, enable gating and reset. Second instance covers bad index.
module tb_servo_pwm_multi;

    localparam int PERIOD = 100;

    logic       clk = 1'b0;
    logic       rstn, en;
    logic       pos_wr, pos_wr3;
    logic [1:0] pos_ch, pos_ch3;
    logic [3:0] pos_data, pos_data3;
    logic [19:0] slew;
    logic [3:0] pwm;
    logic [2:0] pwm3;
    logic       frame_start, frame_start3;

    int errors = 0;
    int checks = 0;

    logic [31:0] wv;
    logic [23:0] wv3;
    int fs;
    int waited;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH(4), .PERIOD(100), .MIN_PULSE(10), .MAX_PULSE(20),
        .POS_W(4), .SLEW_W(20)
    ) u_dut (
        .clk(clk), .rstn(rstn), .en(en),
        .pos_wr(pos_wr), .pos_ch(pos_ch), .pos_data(pos_data),
        .slew(slew), .pwm(pwm), .frame_start(frame_start)
    );

    servo_pwm_multi #(
        .NUM_CH(3), .PERIOD(100), .MIN_PULSE(10), .MAX_PULSE(20),
        .POS_W(4), .SLEW_W(20)
    ) u_dut3 (
        .clk(clk), .rstn(rstn), .en(en),
        .pos_wr(pos_wr3), .pos_ch(pos_ch3), .pos_data(pos_data3),
        .slew(slew), .pwm(pwm3), .frame_start(frame_start3)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for frame_start, then counts high cycles over one frame.
    // Optionally issues one write at a given offset into the frame.
    task automatic measure(input bit wr, input bit to3, input int off,
                           input logic [1:0] ch, input logic [3:0] data);
        int c [4];
        int c3 [3];
        for (int i = 0; i < 4; i++) c[i] = 0;
        for (int i = 0; i < 3; i++) c3[i] = 0;
        fs = 0;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (frame_start !== 1'b1 && waited < 2 * PERIOD);
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no frame_start in %0d cycles", waited);
        end
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) tick();
            for (int i = 0; i < 4; i++) c[i] += int'(pwm[i]);
            for (int i = 0; i < 3; i++) c3[i] += int'(pwm3[i]);
            fs += int'(frame_start);
            pos_wr  = 1'b0;
            pos_wr3 = 1'b0;
            if (wr && k == off) begin
                if (to3) begin
                    pos_wr3 = 1'b1; pos_ch3 = ch; pos_data3 = data;
                end else begin
                    pos_wr = 1'b1; pos_ch = ch; pos_data = data;
                end
            end
        end
        wv  = {8'(c[3]), 8'(c[2]), 8'(c[1]), 8'(c[0])};
        wv3 = {8'(c3[2]), 8'(c3[1]), 8'(c3[0])};
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; slew = '0;
        pos_wr = 1'b0; pos_ch = '0; pos_data = '0;
        pos_wr3 = 1'b0; pos_ch3 = '0; pos_data3 = '0;
        repeat (3) tick();
        checks++;
        if ({pwm, pwm3, frame_start, frame_start3} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0",
                     {pwm, pwm3, frame_start, frame_start3});
        end
        rstn = 1'b1;
        en   = 1'b1;
    endtask

    task automatic test_centre();
        for (int f = 0; f < 2; f++) begin
            measure(0, 0, 0, 2'd0, 4'd0);
            checks++;
            if (waited !== 1) begin
                errors++;
                $display("FAIL centre_start f%0d: waited %0d want 1", f, waited);
            end
            checks++;
            if (wv !== {4{8'd15}}) begin
                errors++;
                $display("FAIL centre_width f%0d: got %h want 0f0f0f0f", f, wv);
            end
            checks++;
            if (fs !== 1) begin
                errors++;
                $display("FAIL centre_fs f%0d: got %0d want 1", f, fs);
            end
        end
    endtask

    task automatic test_write_midframe();
        measure(1, 0, 50, 2'd2, 4'd15);
        checks++;
        if (wv !== {4{8'd15}}) begin
            errors++;
            $display("FAIL mid_cur_frame: got %h want 0f0f0f0f", wv);
        end
        measure(1, 0, 50, 2'd2, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd19, 8'd15, 8'd15}) begin
            errors++;
            $display("FAIL mid_next_frame: got %h want 0f130f0f", wv);
        end
        measure(0, 0, 0, 2'd0, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd15, 8'd15}) begin
            errors++;
            $display("FAIL mid_pos0: got %h want 0f0a0f0f", wv);
        end
    endtask

    task automatic test_slew();
        int exp0 [9];
        exp0 = '{15, 17, 19, 19, 17, 15, 13, 11, 10};
        slew = 20'd2;
        for (int k = 0; k < 9; k++) begin
            if (k == 0)
                measure(1, 0, 50, 2'd0, 4'd15);
            else if (k == 3)
                measure(1, 0, 50, 2'd0, 4'd0);
            else
                measure(0, 0, 0, 2'd0, 4'd0);
            checks++;
            if (wv !== {8'd15, 8'd10, 8'd15, 8'(exp0[k])}) begin
                errors++;
                $display("FAIL slew_frame%0d: got %h want ch0=%0d", k, wv, exp0[k]);
            end
        end
        slew = '0;
    endtask

    task automatic test_boundary_write();
        measure(1, 0, 98, 2'd1, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd15, 8'd10}) begin
            errors++;
            $display("FAIL bnd_frame0: got %h want 0f0a0f0a", wv);
        end
        measure(0, 0, 0, 2'd0, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd15, 8'd10}) begin
            errors++;
            $display("FAIL bnd_frame1: got %h want 0f0a0f0a", wv);
        end
        measure(1, 1, 30, 2'd3, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd10, 8'd10}) begin
            errors++;
            $display("FAIL bnd_frame2: got %h want 0f0a0a0a", wv);
        end
        checks++;
        if (wv3 !== {3{8'd15}}) begin
            errors++;
            $display("FAIL badch_frame0: got %h want 0f0f0f", wv3);
        end
        measure(0, 0, 0, 2'd0, 4'd0);
        checks++;
        if (wv3 !== {3{8'd15}}) begin
            errors++;
            $display("FAIL badch_frame1: got %h want 0f0f0f", wv3);
        end
    endtask

    task automatic test_enable();
        logic seen;
        measure(0, 0, 0, 2'd0, 4'd0);
        repeat (5) tick();
        en = 1'b0;
        tick();
        checks++;
        if ({pwm, frame_start} !== 5'd0) begin
            errors++;
            $display("FAIL en_drop: got %b want 00000", {pwm, frame_start});
        end
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | (|pwm) | frame_start;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL en_idle: got activity %b want 0", seen);
        end
        en = 1'b1;
        measure(0, 0, 0, 2'd0, 4'd0);
        checks++;
        if (waited !== 1) begin
            errors++;
            $display("FAIL en_rise_start: waited %0d want 1", waited);
        end
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd10, 8'd10}) begin
            errors++;
            $display("FAIL en_rise_width: got %h want 0f0a0a0a", wv);
        end
    endtask

    task automatic test_reset_mid();
        measure(1, 0, 2, 2'd3, 4'd0);
        checks++;
        if (wv !== {8'd15, 8'd10, 8'd10, 8'd10}) begin
            errors++;
            $display("FAIL rst_pre: got %h want 0f0a0a0a", wv);
        end
        repeat (6) tick();
        rstn = 1'b0;
        tick();
        checks++;
        if ({pwm, pwm3, frame_start} !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid: got %b want 0", {pwm, pwm3, frame_start});
        end
        rstn = 1'b1;
        for (int f = 0; f < 2; f++) begin
            measure(0, 0, 0, 2'd0, 4'd0);
            checks++;
            if (waited !== 1 || fs !== 1) begin
                errors++;
                $display("FAIL rst_frame_start f%0d: waited %0d fs %0d want 1 1",
                         f, waited, fs);
            end
            checks++;
            if (wv !== {4{8'd15}}) begin
                errors++;
                $display("FAIL rst_width f%0d: got %h want 0f0f0f0f", f, wv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_centre();
        test_write_midframe();
        test_slew();
        test_boundary_write();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
